// File: rtl/prng_health_fifo_if.sv
// Generator sample input and valid/ready word output of the PRNG health FIFO.
interface prng_health_fifo_if #(
    parameter int N = 32
);
    logic [N-1:0] rng_data;
    logic         rng_en;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    modport master (
        output rng_data, rng_en, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  rng_data, rng_en, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/prng_health_fifo.sv
// PRNG health FIFO: startup discard, repetition-count test, FWFT buffer; PRNG_HEALTH_WHITEN_EN xors in the previous sample.
// Latency: a word sampled at edge t is presented at out_valid/out_data after that edge.
// Backpressure: full FIFO drops samples into drop_cnt unless a pop frees a slot that cycle; a fault flushes and blocks output.
module prng_health_fifo #(
    parameter int N          = 32,
    parameter int DEPTH      = 8,
    parameter int DISCARD    = 16,
    parameter int RCT_CUTOFF = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    prng_health_fifo_if.slave          bus,
    input  logic                       clear_fail,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       health_fail,
    output logic [7:0]                 drop_cnt
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = $clog2(DEPTH + 1);
    localparam int DCW = $clog2(DISCARD + 1);
    localparam int RW  = $clog2(RCT_CUTOFF + 1);
    localparam logic [LW-1:0]  LVL_FULL  = LW'(DEPTH);
    localparam logic [DCW-1:0] DISC_LAST = DCW'(DISCARD - 1);
    localparam logic [RW-1:0]  CUTOFF    = RW'(RCT_CUTOFF);

    typedef enum logic [1:0] {STARTUP, RUN, FAIL} state_t;

    state_t         state, state_nxt;
    logic [DCW-1:0] disc_cnt;
    logic [RW-1:0]  rep_cnt, rep_nxt;
    logic [N-1:0]   last_sample, wdata;
    logic [N-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  level;
    logic           sample, trip, pop, push, drop, want_write;

    always_comb begin
        sample     = bus.rng_en && (state != FAIL);
        // rep_cnt==0 marks the first sample after reset/clear: no comparison
        if (rep_cnt != '0 && bus.rng_data == last_sample)
            rep_nxt = (rep_cnt == CUTOFF) ? CUTOFF : rep_cnt + 1'b1;
        else
            rep_nxt = RW'(1);
        trip       = sample && (rep_nxt == CUTOFF);
        pop        = bus.out_valid && bus.out_ready;
        want_write = sample && (state == RUN) && !trip;
        push       = want_write && ((level != LVL_FULL) || pop);
        drop       = want_write && !push;
`ifdef PRNG_HEALTH_WHITEN_EN
        wdata      = bus.rng_data ^ last_sample;
`else
        wdata      = bus.rng_data;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            STARTUP: begin
                if (trip)
                    state_nxt = FAIL;
                else if (sample && disc_cnt == DISC_LAST)
                    state_nxt = RUN;
            end
            RUN:     if (trip) state_nxt = FAIL;
            FAIL:    if (clear_fail) state_nxt = STARTUP;
            default: state_nxt = STARTUP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= STARTUP;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disc_cnt    <= '0;
            rep_cnt     <= '0;
            last_sample <= '0;
            drop_cnt    <= '0;
        end else if (state == FAIL) begin
            if (clear_fail) begin
                disc_cnt <= '0;
                rep_cnt  <= '0;
                drop_cnt <= '0;
            end
        end else if (sample) begin
            last_sample <= bus.rng_data;
            rep_cnt     <= rep_nxt;
            if (state == STARTUP)
                disc_cnt <= disc_cnt + 1'b1;
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // The cutoff sample flushes the buffer on the same edge that enters FAIL
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (trip) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    assign bus.out_valid = (level != '0) && (state != FAIL);
    assign bus.out_data  = mem[rd_ptr];
    assign fifo_level    = level;
    assign health_fail   = (state == FAIL);
endmodule

// File: doc/prng_health_fifo.md
Name: prng_health_fifo

Overview:
Downstream consumer of the 32-bit PRNG mixer output. Samples one generator word per enabled cycle and runs a startup discard phase. Applies a repetition-count health test and buffers accepted words in a first-word-fall-through FIFO with a valid/ready interface to the system. On a health failure it latches a fault, flushes the FIFO and blocks output until software clears the fault.

Parameters:
N, 32, data word width
DEPTH, 8, FIFO depth in words; power of two, minimum 2
DISCARD, 16, number of sampled words dropped after reset/clear before buffering starts; minimum 1
RCT_CUTOFF, 4, consecutive identical samples that trigger a fault; minimum 2

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
rng_data  input  N  generator word, new value each cycle
rng_en  input  1  sample rng_data this cycle
clear_fail  input  1  single-cycle pulse: leave FAIL, restart STARTUP
out_ready  input  1  consumer ready
out_valid  output  1  out_data holds a valid word
out_data  output  N  FIFO head word
fifo_level  output  $clog2(DEPTH+1)  words stored
health_fail  output  1  fault latched (high exactly in FAIL)
drop_cnt  output  8  saturating count of samples lost to a full FIFO

Behaviour:
- Reset: all outputs 0, FIFO empty, state STARTUP, discard counter 0, rep_cnt 0, last-sample register 0.
- Reset is asynchronous and active-low on clk. Asserting reset mid-operation discards FIFO contents immediately.
- Sample: a cycle with rng_en=1. The last-sample register is updated on every sample in STARTUP and RUN.
- Repetition test, active in STARTUP and RUN:
  - rng_data equal to the last sample -> rep_cnt+1, saturating at RCT_CUTOFF.
  - Otherwise rep_cnt=1.
  - The first sample after reset or clear sets rep_cnt=1 without comparing.
  - A sample that makes rep_cnt reach RCT_CUTOFF is not written. The state becomes FAIL on the next edge.
- States:
  - STARTUP: samples are not written; discard counter increments per sample. The DISCARD-th sample moves to RUN and is itself discarded.
  - RUN: each passing sample is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle. Otherwise drop_cnt+1, saturating at 255.
  - FAIL: entered from STARTUP or RUN on the edge after the cutoff sample. On entry the FIFO is flushed (level 0). rng_en is ignored; out_valid=0; health_fail=1.
    - clear_fail=1 -> STARTUP: discard counter 0, rep_cnt 0, drop_cnt 0.
    - clear_fail in STARTUP or RUN has no effect.
- FIFO:
  - out_valid = level!=0 and state!=FAIL. out_data = head word.
  - Pop when out_valid && out_ready.
  - A word written at edge t is visible at out_valid after that edge (1-cycle latency).
  - Simultaneous push and pop: level unchanged. Push and pop on an empty FIFO: the push only, since out_valid=0.
  - Pointers wrap modulo DEPTH.
- out_data and the memory are not reset-cleared. out_data is don't-care while out_valid=0.

Optional Feature:
PRNG_HEALTH_WHITEN_EN
- Defined: the written word is rng_data XOR the last-sample register's value before the update. The repetition test still uses raw rng_data.
- Undefined: rng_data is written unmodified and no extra XOR logic is present.

Test Plan:
All cases use DISCARD=4, DEPTH=8, RCT_CUTOFF=3, no whiten.
1. Reset, then rng_en=1 with distinct words 1,2,3,...:
   - words 1-4 are discarded.
   - out_valid rises the cycle after word 5 is sampled, with out_data=5.
2. out_ready=0, 12 distinct samples after startup:
   - fifo_level=8, drop_cnt=4.
   - Then out_ready=1: pops return 5..12 in order.
3. FIFO full with out_ready=1 and rng_en=1 each cycle: level stays 8, drop_cnt does not change.
4. In RUN, feed A,A,A:
   - the first two A are written and the third is not.
   - health_fail=1 on the next edge; fifo_level=0, out_valid=0.
   - further samples are ignored.
5. In FAIL, pulse clear_fail:
   - state becomes STARTUP, health_fail=0, drop_cnt=0.
   - the next 4 samples are discarded and the 5th appears at out_data.
6. Assert reset_n low mid-stream with a non-empty FIFO:
   - out_valid=0 and fifo_level=0 immediately, without a clock edge.
   - Under PRNG_HEALTH_WHITEN_EN, samples 4 then 5 produce out_data = 4^5 = 1.
